// File: rtl/rd_win_pkg.sv
// Shared types and helpers for the rd/rd_ack window arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rd_win_pkg;

  // Window FSM states: waiting for a request, window open, enforced quiet gap.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OPEN = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // $clog2 that never returns less than 1, so single-value fields still get a bit.
  function automatic int clog2_min1(input int v);
    int r;
    r = $clog2(v);
    return (r < 1) ? 1 : r;
  endfunction

  // Default requester count and the matching grant index width.
  localparam int N_REQ_DEF = 2;
  localparam int ID_W      = clog2_min1(N_REQ_DEF);

endpackage

// File: rtl/rd_win_rr_arb.sv
// Round-robin picker: first requester after the last winner, wrapping.
// Latency: combinational pick; pointer updates on the clock after load_en.
// Backpressure: pointer only advances when the caller actually takes the grant.
module rd_win_rr_arb
  import rd_win_pkg::*;
#(
  parameter  int N_REQ = N_REQ_DEF,
  localparam int GID_W = clog2_min1(N_REQ)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             load_en,
  output logic             gnt_valid,
  output logic [GID_W-1:0] gnt_idx
);

  logic [GID_W-1:0]   ptr_q;
  logic [GID_W-1:0]   ptr_d;
  logic [2*N_REQ-1:0] rot;
  logic               found;
  int                 sum;

  // Pointer starts at the last index so requester 0 is favoured after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ptr_q <= GID_W'(N_REQ - 1);
    else        ptr_q <= ptr_d;
  end

  // Rotate the request vector so bit 0 is the requester just after the pointer.
  always_comb begin
    gnt_valid = |req;
    gnt_idx   = '0;
    found     = 1'b0;
    sum       = 0;
    rot       = {req, req} >> (int'(ptr_q) + 1);
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = int'(ptr_q) + 1 + k;
        if (sum >= N_REQ) sum = sum - N_REQ;
        gnt_idx = GID_W'(sum);
      end
    end
    ptr_d = load_en ? gnt_idx : ptr_q;
  end

endmodule

// File: rtl/rd_window_arbiter.sv
// Grants one requester at a time a read window; data_out frozen while rd=1.
// Latency: req -> rd one cycle; rd_ack -> rd low and done pulse one cycle.
// Backpressure: windows stay open until rd_ack (or timeout); no new window while rd_ack=1.
module rd_window_arbiter
  import rd_win_pkg::*;
#(
  parameter  int N_REQ   = N_REQ_DEF,
  parameter  int WIDTH   = 4,
  parameter  int GAP     = 1,
  parameter  int TIMEOUT = 16,
  localparam int GID_W   = clog2_min1(N_REQ)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       done,
  output logic [N_REQ-1:0]       err,
  output logic                   rd,
  output logic [WIDTH-1:0]       data_out,
  input  logic                   rd_ack,
  output logic                   busy,
  output logic [GID_W-1:0]       grant_id
);

  localparam int              TO_W     = clog2_min1(TIMEOUT + 1);
  localparam int              GC_W     = clog2_min1(GAP);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [GC_W-1:0] GAP_LAST = GC_W'(GAP - 1);

  state_t           state_q, state_d;
  logic             rd_q, rd_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [GID_W-1:0] gid_q, gid_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [N_REQ-1:0] err_q, err_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [GC_W-1:0]  gap_cnt_q, gap_cnt_d;

  logic             gnt_valid;
  logic [GID_W-1:0] gnt_idx;
  logic             load_en;
  logic [WIDTH-1:0] sel_dat;
  logic [N_REQ-1:0] gid_oh;

  // Only grant from IDLE, and never open a window into a still-high rd_ack.
  assign load_en = (state_q == S_IDLE) && gnt_valid && !rd_ack;

  rd_win_rr_arb #(.N_REQ(N_REQ)) u_arb (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .load_en   (load_en),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Select the candidate winner's data slice.
  always_comb begin
    sel_dat = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (GID_W'(i) == gnt_idx) sel_dat = req_data[i*WIDTH +: WIDTH];
    end
  end

  assign gid_oh = N_REQ'(1) << gid_q;

  // State, window data and counters; reset drops rd immediately, no pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      rd_q      <= 1'b0;
      data_q    <= '0;
      gid_q     <= '0;
      done_q    <= '0;
      err_q     <= '0;
      to_cnt_q  <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      data_q    <= data_d;
      gid_q     <= gid_d;
      done_q    <= done_d;
      err_q     <= err_d;
      to_cnt_q  <= to_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  // Next-state logic; data_q is only written on the IDLE->OPEN transition.
  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    data_d    = data_q;
    gid_d     = gid_q;
    done_d    = '0;
    err_d     = '0;
    to_cnt_d  = to_cnt_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (load_en) begin
          state_d  = S_OPEN;
          rd_d     = 1'b1;
          data_d   = sel_dat;
          gid_d    = gnt_idx;
          to_cnt_d = '0;
        end
      end
      S_OPEN: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (rd_ack) begin
          state_d   = S_GAP;
          rd_d      = 1'b0;
          done_d    = gid_oh;
          gap_cnt_d = '0;
        end else if ((TIMEOUT != 0) && (to_cnt_q == TO_LAST)) begin
          state_d   = S_GAP;
          rd_d      = 1'b0;
          err_d     = gid_oh;
          gap_cnt_d = '0;
        end
      end
      S_GAP: begin
        if (gap_cnt_q != GAP_LAST) gap_cnt_d = gap_cnt_q + GC_W'(1);
        else if (!rd_ack)          state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rd       = rd_q;
  assign data_out = data_q;
  assign done     = done_q;
  assign err      = err_q;
  assign grant_id = gid_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_rd_window_arbiter.sv
// Directed bench for rd_window_arbiter with default parameters.
// Inputs change 1 time unit after the rising edge; outputs are read there too.
// Every check is an immediate assertion against a hand-computed value.
module tb_rd_window_arbiter;

  logic       clock;
  logic       reset;
  logic [1:0] req;
  logic [7:0] req_data;
  logic [1:0] done;
  logic [1:0] err;
  logic       rd;
  logic [3:0] data_out;
  logic       rd_ack;
  logic       busy;
  logic [0:0] grant_id;

  int n_run;
  int n_fail;

  rd_window_arbiter #(.N_REQ(2), .WIDTH(4), .GAP(1), .TIMEOUT(16)) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .done     (done),
    .err      (err),
    .rd       (rd),
    .data_out (data_out),
    .rd_ack   (rd_ack),
    .busy     (busy),
    .grant_id (grant_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    req    = 2'b00;
    rd_ack = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hi;
    int guard;
    int ex;
    n_run    = 0;
    n_fail   = 0;
    reset    = 1'b0;
    req      = 2'b00;
    req_data = 8'h00;
    rd_ack   = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_rd", rd, 1'b0);
    chk("rst_data", data_out, 4'h0);
    chk("rst_done", done, 2'b00);
    chk("rst_err", err, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_gid", grant_id, 1'b0);
    reset = 1'b1;
    tick();

    // Single request, ack 5 cycles after rd rises
    req_data[3:0] = 4'hF;
    req = 2'b01;
    tick();
    chk("t1_rd_rise", rd, 1'b1);
    chk("t1_data", data_out, 4'hF);
    chk("t1_gid", grant_id, 1'b0);
    chk("t1_busy", busy, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t1_rd_hold", rd, 1'b1);
      chk("t1_data_hold", data_out, 4'hF);
    end
    rd_ack = 1'b1;
    tick();
    chk("t1_rd_fall", rd, 1'b0);
    chk("t1_done", done, 2'b01);
    chk("t1_err", err, 2'b00);
    chk("t1_data_gap", data_out, 4'hF);
    req = 2'b00;
    rd_ack = 1'b0;
    tick();
    chk("t1_done_clr", done, 2'b00);
    chk("t1_rd_low", rd, 1'b0);
    chk("t1_idle", busy, 1'b0);
    chk("t1_data_idle", data_out, 4'hF);

    // Source data changes while the window is open
    req = 2'b01;
    tick();
    chk("t2_rd", rd, 1'b1);
    chk("t2_data0", data_out, 4'hF);
    req_data[3:0] = 4'hE;
    tick();
    chk("t2_frozen1", data_out, 4'hF);
    tick();
    chk("t2_frozen2", data_out, 4'hF);
    rd_ack = 1'b1;
    tick();
    chk("t2_done", done, 2'b01);
    chk("t2_data_gap", data_out, 4'hF);
    req = 2'b00;
    rd_ack = 1'b0;
    req_data[3:0] = 4'hC;
    tick();
    chk("t2_idle", busy, 1'b0);
    req = 2'b01;
    tick();
    chk("t2b_rd", rd, 1'b1);
    chk("t2b_data", data_out, 4'hC);
    rd_ack = 1'b1;
    tick();
    chk("t2b_done", done, 2'b01);
    req = 2'b00;
    rd_ack = 1'b0;
    tick();

    // Round robin from reset with both requesting
    do_reset();
    req_data = {4'hC, 4'h3};
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      ex = i % 2;
      tick();
      chk("rr_gid", grant_id, ex[0]);
      chk("rr_rd", rd, 1'b1);
      chk("rr_data", data_out, (ex == 1) ? 4'hC : 4'h3);
      tick();
      rd_ack = 1'b1;
      tick();
      chk("rr_done", done, (ex == 1) ? 2'b10 : 2'b01);
      chk("rr_rd_fall", rd, 1'b0);
      rd_ack = 1'b0;
      if (i == 3) req = 2'b00;
      tick();
      chk("rr_idle", busy, 1'b0);
    end

    // Timeout with rd_ack held low
    req_data[3:0] = 4'h9;
    req = 2'b01;
    tick();
    hi = 0;
    guard = 0;
    while (rd === 1'b1 && guard < 40) begin
      hi++;
      guard++;
      tick();
    end
    chk("to_rd_cycles", hi, 16);
    chk("to_err", err, 2'b01);
    chk("to_done", done, 2'b00);
    req = 2'b00;
    tick();
    chk("to_err_clr", err, 2'b00);
    chk("to_idle", busy, 1'b0);

    // Ack on the 16th cycle wins over timeout
    req = 2'b01;
    tick();
    repeat (15) tick();
    chk("to16_rd", rd, 1'b1);
    rd_ack = 1'b1;
    tick();
    chk("to16_done", done, 2'b01);
    chk("to16_err", err, 2'b00);
    chk("to16_rd_fall", rd, 1'b0);
    req = 2'b00;
    rd_ack = 1'b0;
    tick();

    // Stuck rd_ack blocks the pending requester 1
    req_data = {4'h5, 4'h6};
    req = 2'b01;
    tick();
    chk("st_gid0", grant_id, 1'b0);
    req = 2'b11;
    rd_ack = 1'b1;
    tick();
    chk("st_done0", done, 2'b01);
    req = 2'b10;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("st_rd_blocked", rd, 1'b0);
      chk("st_busy", busy, 1'b1);
    end
    rd_ack = 1'b0;
    tick();
    chk("st_rd_gap", rd, 1'b0);
    tick();
    chk("st_rd1", rd, 1'b1);
    chk("st_gid1", grant_id, 1'b1);
    chk("st_data1", data_out, 4'h5);
    rd_ack = 1'b1;
    tick();
    chk("st_done1", done, 2'b10);
    req = 2'b00;
    rd_ack = 1'b0;
    tick();

    // Reset asserted mid-window
    req_data = {4'h5, 4'hA};
    req = 2'b01;
    tick();
    chk("mr_rd", rd, 1'b1);
    #3;
    reset = 1'b0;
    #1;
    chk("mr_rd_async", rd, 1'b0);
    chk("mr_data_async", data_out, 4'h0);
    chk("mr_busy_async", busy, 1'b0);
    chk("mr_done", done, 2'b00);
    chk("mr_err", err, 2'b00);
    req = 2'b11;
    tick();
    reset = 1'b1;
    tick();
    chk("mr_gid_first", grant_id, 1'b0);
    chk("mr_rd_again", rd, 1'b1);
    chk("mr_data_again", data_out, 4'hA);
    chk("mr_no_done", done, 2'b00);
    chk("mr_no_err", err, 2'b00);
    req = 2'b00;
    rd_ack = 1'b1;
    tick();
    chk("mr_done_end", done, 2'b01);
    rd_ack = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/rd_window_arbiter.md
Name: rd_window_arbiter

Overview:
- Arbitrates N requesters onto one shared 1-deep read channel with an rd / rd_ack window handshake.
- Captures the winner's data into a holding register and asserts rd.
- Holds data_out bit-stable from rd rise until rd_ack closes the window, so an ovl_win_unchange checker with start_event=rd, test_expr=data_out, end_event=rd_ack never fires.
- Adds round-robin fairness, a minimum inter-window gap and an optional ack timeout.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- WIDTH, 4, data width.
- GAP, 1, minimum cycles rd stays low between windows (>=1).
- TIMEOUT, 16, max cycles waiting for rd_ack; 0 disables the timeout.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester level request; held until done or err.
- req_data  in  N_REQ*WIDTH  requester i data in slice [i*WIDTH +: WIDTH].
- done  out  N_REQ  one-cycle pulse: requester's window closed by rd_ack.
- err  out  N_REQ  one-cycle pulse: requester's window aborted by timeout.
- rd  out  1  window open (start_event).
- data_out  out  WIDTH  held data, stable while rd=1.
- rd_ack  in  1  level acknowledge from consumer (end_event).
- busy  out  1  high in any state other than IDLE.
- grant_id  out  $clog2(N_REQ) (min 1)  index of current or last granted requester.

Behaviour:
- Reset (reset=0, async): rd=0, data_out=0, done=0, err=0, busy=0, grant_id=0, state=IDLE, counters=0, rr pointer=N_REQ-1 (requester 0 wins first).
- States and transitions:
  - IDLE: if any req is high, pick the winner by round-robin starting at pointer+1. Next cycle: data_out<=req_data[winner], grant_id<=winner, rd<=1, pointer<=winner, go to OPEN. Latency req->rd is 1 cycle.
  - OPEN: rd=1, data_out frozen. Counter increments each cycle.
    - rd_ack sampled high: rd<=0, done[grant_id] pulses next cycle, go to GAP.
    - Else, if TIMEOUT!=0 and the counter reaches TIMEOUT-1: rd<=0, err[grant_id] pulses, go to GAP.
    - rd_ack takes priority if it coincides with the timeout cycle.
  - GAP: rd=0. Stay at least GAP cycles and until rd_ack is sampled low, then go to IDLE. A stuck-high rd_ack therefore blocks new windows, and no window is ever opened while rd_ack=1.
- data_out changes only on the IDLE->OPEN transition; it holds its last value in GAP and IDLE.
- A requester dropping req during OPEN does not abort the window; done is still pulsed.
- Requests are sampled only in IDLE. A req raised during OPEN or GAP waits.
- With all N_REQ requesting continuously, grants rotate 0,1,...,N_REQ-1,0.
- The requester receiving done or err must drop req within 1 cycle, otherwise it is treated as a new request at its rr turn.
- The timeout counter clears on entry to OPEN and is sized $clog2(TIMEOUT+1) bits. The GAP counter is separate.
- Reset asserted mid-window: rd drops asynchronously and no done/err pulse is issued.

Decomposition:
- Package rd_win_pkg:
  - state_t enum {IDLE, OPEN, GAP}.
  - function clog2_min1.
  - localparam ID_W.
- Sub-module rd_win_rr_arb:
  - Registered rr pointer plus combinational one-hot/index pick.
  - Inputs: req, load_en. Outputs: gnt_valid, gnt_idx.
- Top holds the FSM, data register and counters.

Test Plan:
- Single request: req[0]=1, req_data[0]=4'b1111; rd_ack rises 5 cycles after rd. Expect rd=1 one cycle after req, data_out=4'hF constant while rd=1, done[0] pulse, rd low for >=GAP cycles. An ovl_win_unchange instance is bound and must report no fire.
- Changing source data: in OPEN, change req_data[0] 4'hF->4'hE. Expect data_out to remain 4'hF until rd_ack. The next window, with data 4'hC held steady, completes with done[0].
- Round-robin: req=2'b11 held, data 4'h3/4'hC, rd_ack is an echo of rd delayed 2 cycles. Expect grant_id sequence 0,1,0,1 and alternating done[0], done[1].
- Timeout: TIMEOUT=16, rd_ack held 0. Expect rd high exactly 16 cycles, err[grant_id] pulse, done=0, then IDLE. Ack on the 16th cycle yields done, not err.
- Stuck rd_ack: rd_ack held 1 after a window with req[1]=1 pending. Expect rd to stay 0 until rd_ack=0, then rd rises for requester 1 after >=GAP cycles.
- Reset mid-window: drive reset=0 while rd=1. Expect rd, data_out, busy to be 0 immediately with no done/err pulse. After release, requester 0 has first priority.
